// File: rtl/exception_ctrl_if.sv
// M-stage exception bundle: instruction state in,
// flush/redirect and CP0 commit data out.
interface exception_ctrl_if;
  logic        valid_m;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [31:0] mem_addr_m;
  logic        adel_if;
  logic        adel_mem;
  logic        ades;
  logic        syscall;
  logic        brk;
  logic        eret;
  logic        ri;
  logic        ov;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        exc_commit;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_epc;
  logic        badvaddr_we;
  logic [31:0] badvaddr;
  logic        eret_commit;

  modport master (
    output valid_m, pc_m, bd_m, mem_addr_m,
    output adel_if, adel_mem, ades, syscall,
    output brk, eret, ri, ov,
    input  flush, redirect_pc, exc_commit,
    input  exc_code, exc_bd, exc_epc,
    input  badvaddr_we, badvaddr, eret_commit
  );

  modport slave (
    input  valid_m, pc_m, bd_m, mem_addr_m,
    input  adel_if, adel_mem, ades, syscall,
    input  brk, eret, ri, ov,
    output flush, redirect_pc, exc_commit,
    output exc_code, exc_bd, exc_epc,
    output badvaddr_we, badvaddr, eret_commit
  );
endinterface

// File: rtl/exception_ctrl.sv
// M-stage exception/interrupt resolver with registered
// flush pulse, interrupt synchroniser and Count/Compare timer.
module exception_ctrl #(
  parameter int          NUM_EXT_INT = 6,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter bit          TIMER_EN    = 1'b1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_EXT_INT-1:0] ext_int,
  exception_ctrl_if.slave        m,
  input  logic [31:0]            cp0_status,
  input  logic [31:0]            cp0_cause,
  input  logic [31:0]            cp0_epc,
  input  logic                   cp0_we,
  input  logic [4:0]             cp0_waddr,
  input  logic [31:0]            cp0_wdata,
  output logic [5:0]             hw_ip,
  output logic                   timer_int,
  output logic [31:0]            count,
  output logic [31:0]            compare
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAKEN = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state;

  logic [NUM_EXT_INT-1:0] sync_q [SYNC_STAGES];
  logic [5:0]             ext_ip;
  logic                   int_req;
  logic                   det;
  logic                   is_eret;
  logic                   bad_we;
  logic [4:0]             code;
  logic [31:0]            bad_addr;

  // Metastability chain on each external interrupt line
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= ext_int;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign ext_ip = 6'(sync_q[SYNC_STAGES-1]);
  assign hw_ip  = {ext_ip[5] | timer_int, ext_ip[4:0]};

  assign int_req = (|({hw_ip, cp0_cause[9:8]}
                      & cp0_status[15:8]))
                   && !cp0_status[1]
                   && cp0_status[0];

  // Priority pick of the cause for the M instruction
  always_comb begin
    det      = 1'b1;
    is_eret  = 1'b0;
    bad_we   = 1'b0;
    code     = 5'h00;
    bad_addr = m.mem_addr_m;
    priority case (1'b1)
      int_req: code = 5'h00;
      m.adel_if: begin
        code     = 5'h04;
        bad_we   = 1'b1;
        bad_addr = m.pc_m;
      end
      m.adel_mem: begin
        code   = 5'h04;
        bad_we = 1'b1;
      end
      m.ades: begin
        code   = 5'h05;
        bad_we = 1'b1;
      end
      m.syscall: code = 5'h08;
      m.brk:     code = 5'h09;
      m.eret:    is_eret = 1'b1;
      m.ri:      code = 5'h0A;
      m.ov:      code = 5'h0C;
      default:   det = 1'b0;
    endcase
  end

  // Take/hold FSM; outputs pulse for one cycle after a decision
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      m.flush       <= 1'b0;
      m.redirect_pc <= '0;
      m.exc_commit  <= 1'b0;
      m.exc_code    <= '0;
      m.exc_bd      <= 1'b0;
      m.exc_epc     <= '0;
      m.badvaddr_we <= 1'b0;
      m.badvaddr    <= '0;
      m.eret_commit <= 1'b0;
    end else begin
      m.flush       <= 1'b0;
      m.redirect_pc <= '0;
      m.exc_commit  <= 1'b0;
      m.exc_code    <= '0;
      m.exc_bd      <= 1'b0;
      m.exc_epc     <= '0;
      m.badvaddr_we <= 1'b0;
      m.badvaddr    <= '0;
      m.eret_commit <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m.valid_m && det) begin
            state         <= TAKEN;
            m.flush       <= 1'b1;
            m.eret_commit <= is_eret;
            m.exc_commit  <= !is_eret;
            if (is_eret) begin
              m.redirect_pc <= cp0_epc;
            end else begin
              m.redirect_pc <= EXC_VECTOR;
              m.exc_code    <= code;
              m.exc_bd      <= m.bd_m;
              m.exc_epc     <= m.bd_m ? m.pc_m - 32'd4
                                      : m.pc_m;
              m.badvaddr_we <= bad_we;
              m.badvaddr    <= bad_we ? bad_addr : '0;
            end
          end
        end
        TAKEN:   state <= HOLD;
        HOLD:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (TIMER_EN) begin : g_timer
      logic toggle;
      logic upd;
      logic count_we;
      logic cmp_we;

      assign count_we = cp0_we && (cp0_waddr == 5'd9);
      assign cmp_we   = cp0_we && (cp0_waddr == 5'd11);

      // Half-rate Count, Compare match latches timer_int
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          count     <= '0;
          compare   <= '0;
          toggle    <= 1'b0;
          upd       <= 1'b0;
          timer_int <= 1'b0;
        end else begin
          if (count_we) begin
            count  <= cp0_wdata;
            toggle <= 1'b0;
            upd    <= 1'b1;
          end else begin
            count  <= count + {31'd0, toggle};
            toggle <= ~toggle;
            upd    <= toggle;
          end
          if (cmp_we) begin
            compare   <= cp0_wdata;
            timer_int <= 1'b0;
          end else if (upd && count == compare) begin
            timer_int <= 1'b1;
          end
        end
      end
    end else begin : g_no_timer
      logic unused_timer;
      assign unused_timer = ^{cp0_we, cp0_waddr, cp0_wdata};
      assign count     = '0;
      assign compare   = '0;
      assign timer_int = 1'b0;
    end
  endgenerate

  logic unused_bits;
  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2],
                         cp0_cause[31:10], cp0_cause[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomised self-checking bench for exception_ctrl with a
// priority-table reference model and an arithmetic timer model.
module tb_exception_ctrl;
  localparam int          NEI  = 6;
  localparam int          SYNC = 2;
  localparam logic [31:0] VEC  = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [5:0]  ext_int = '0;
  logic [31:0] cp0_status = '0;
  logic [31:0] cp0_cause = '0;
  logic [31:0] cp0_epc = '0;
  logic        cp0_we = 1'b0;
  logic [4:0]  cp0_waddr = '0;
  logic [31:0] cp0_wdata = '0;
  logic [5:0]  hw_ip;
  logic        timer_int;
  logic [31:0] count;
  logic [31:0] compare;

  int errors = 0;
  int checks = 0;

  exception_ctrl_if bus ();

  exception_ctrl #(
    .NUM_EXT_INT(NEI),
    .SYNC_STAGES(SYNC),
    .EXC_VECTOR(VEC),
    .TIMER_EN(1'b1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .ext_int(ext_int),
    .m(bus),
    .cp0_status(cp0_status),
    .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc),
    .cp0_we(cp0_we),
    .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata),
    .hw_ip(hw_ip),
    .timer_int(timer_int),
    .count(count),
    .compare(compare)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [7:0] f);
    bus.adel_if  = f[0];
    bus.adel_mem = f[1];
    bus.ades     = f[2];
    bus.syscall  = f[3];
    bus.brk      = f[4];
    bus.eret     = f[5];
    bus.ri       = f[6];
    bus.ov       = f[7];
  endtask

  task automatic clear_m();
    bus.valid_m    = 1'b0;
    bus.pc_m       = '0;
    bus.bd_m       = 1'b0;
    bus.mem_addr_m = '0;
    set_flags(8'h00);
  endtask

  task automatic cp0_write(input logic [4:0] a,
                           input logic [31:0] d);
    cp0_we    = 1'b1;
    cp0_waddr = a;
    cp0_wdata = d;
    tick();
    cp0_we    = 1'b0;
  endtask

  function automatic logic [3:0] pulses();
    return {bus.flush, bus.exc_commit,
            bus.eret_commit, bus.badvaddr_we};
  endfunction

  task automatic test_reset();
    clear_m();
    #2;
    checks++;
    if ({pulses(), timer_int, hw_ip} !== 11'd0) begin
      errors++;
      $display("FAIL reset_pulses got=%b want=0",
               {pulses(), timer_int, hw_ip});
    end
    checks++;
    if ({count, compare} !== 64'd0) begin
      errors++;
      $display("FAIL reset_timer count=%h compare=%h want=0",
               count, compare);
    end
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (pulses() !== 4'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_pulses got=%0d bad cycles want=0", bad);
    end
    checks++;
    if (count !== 32'd5) begin
      errors++;
      $display("FAIL idle_count got=%0d want=5", count);
    end
    checks++;
    if (hw_ip !== 6'd0) begin
      errors++;
      $display("FAIL idle_hw_ip got=%b want=0", hw_ip);
    end
  endtask

  task automatic test_ov();
    bus.valid_m = 1'b1;
    bus.pc_m    = 32'hBFC00100;
    bus.bd_m    = 1'b0;
    set_flags(8'h80);
    tick();
    clear_m();
    checks++;
    if ({pulses(), bus.redirect_pc, bus.exc_code, bus.exc_epc}
        !== {4'b1100, VEC, 5'h0C, 32'hBFC00100}) begin
      errors++;
      $display("FAIL ov p=%b pc=%h code=%h epc=%h",
               pulses(), bus.redirect_pc, bus.exc_code,
               bus.exc_epc);
    end
    tick();
    checks++;
    if (pulses() !== 4'd0) begin
      errors++;
      $display("FAIL ov_one_cycle got=%b want=0000", pulses());
    end
    tick();
  endtask

  task automatic test_combo();
    bus.valid_m    = 1'b1;
    bus.pc_m       = 32'h80000010;
    bus.bd_m       = 1'b1;
    bus.mem_addr_m = 32'h00000003;
    set_flags(8'h0A);
    tick();
    clear_m();
    checks++;
    if ({pulses(), bus.exc_code, bus.badvaddr, bus.exc_bd,
         bus.exc_epc}
        !== {4'b1101, 5'h04, 32'h3, 1'b1, 32'h8000000C}) begin
      errors++;
      $display("FAIL combo p=%b code=%h bva=%h bd=%b epc=%h",
               pulses(), bus.exc_code, bus.badvaddr,
               bus.exc_bd, bus.exc_epc);
    end
    tick();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] codes [8];
    logic [7:0] f;
    logic [31:0] pc, ma, epc;
    logic bd;
    int win;
    codes = '{5'h04, 5'h04, 5'h05, 5'h08,
              5'h09, 5'h00, 5'h0A, 5'h0C};
    for (int n = 0; n < 40; n++) begin
      f   = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) f = 8'h00;
      if ($urandom_range(0, 1) == 1) f = f & ~(f - 8'd1);
      pc  = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      ma  = $urandom;
      epc = $urandom;
      bd  = 1'($urandom_range(0, 1));
      bus.valid_m    = 1'b1;
      bus.pc_m       = pc;
      bus.bd_m       = bd;
      bus.mem_addr_m = ma;
      cp0_epc        = epc;
      set_flags(f);
      win = -1;
      for (int i = 0; i < 8; i++)
        if (f[i] && win < 0) win = i;
      tick();
      clear_m();
      checks++;
      if (win < 0) begin
        if (pulses() !== 4'd0) begin
          errors++;
          $display("FAIL rand_none f=%h got=%b", f, pulses());
        end
      end else if (win == 5) begin
        if ({pulses(), bus.redirect_pc} !== {4'b1010, epc}) begin
          errors++;
          $display("FAIL rand_eret f=%h p=%b pc=%h want=%h",
                   f, pulses(), bus.redirect_pc, epc);
        end
      end else begin
        if ({pulses(), bus.redirect_pc, bus.exc_code, bus.exc_bd,
             bus.exc_epc}
            !== {1'b1, 1'b1, 1'b0, win <= 2, VEC, codes[win], bd,
                 bd ? pc - 32'd4 : pc}) begin
          errors++;
          $display("FAIL rand_exc f=%h p=%b code=%h bd=%b epc=%h",
                   f, pulses(), bus.exc_code, bus.exc_bd,
                   bus.exc_epc);
        end else if (win <= 2 &&
                     bus.badvaddr !== (f[0] ? pc : ma)) begin
          errors++;
          $display("FAIL rand_bva f=%h got=%h want=%h", f,
                   bus.badvaddr, f[0] ? pc : ma);
        end
      end
      tick();
      checks++;
      if (pulses() !== 4'd0) begin
        errors++;
        $display("FAIL rand_one_cycle got=%b want=0000", pulses());
      end
      tick();
    end
  endtask

  task automatic test_eret_hold();
    int bad = 0;
    bus.valid_m = 1'b1;
    bus.pc_m    = 32'h80000040;
    cp0_epc     = 32'h80001234;
    set_flags(8'h20);
    tick();
    set_flags(8'h40);
    checks++;
    if ({pulses(), bus.redirect_pc} !== {4'b1010, 32'h80001234}) begin
      errors++;
      $display("FAIL eret p=%b pc=%h want=1010/80001234",
               pulses(), bus.redirect_pc);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      if (pulses() !== 4'd0) bad++;
    end
    clear_m();
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL eret_hold_ri got=%0d pulses want=0", bad);
    end
    tick();
  endtask

  task automatic test_interrupt();
    int bad = 0;
    cp0_status  = 32'h0000FF01;
    bus.valid_m = 1'b1;
    bus.pc_m    = 32'h80000100;
    ext_int     = 6'b000010;
    for (int k = 1; k <= SYNC + 1; k++) begin
      tick();
      if (k <= SYNC && bus.flush !== 1'b0) bad++;
      if (k == SYNC) begin
        checks++;
        if (hw_ip !== 6'b000010) begin
          errors++;
          $display("FAIL int_hw_ip got=%b want=000010", hw_ip);
        end
      end
    end
    bus.valid_m = 1'b0;
    ext_int     = '0;
    checks++;
    if (bad != 0 || {pulses(), bus.exc_code, bus.exc_epc}
        !== {4'b1100, 5'h00, 32'h80000100}) begin
      errors++;
      $display("FAIL int_taken early=%0d p=%b code=%h epc=%h",
               bad, pulses(), bus.exc_code, bus.exc_epc);
    end
    repeat (SYNC + 3) tick();
    cp0_status  = 32'h0000FF03;
    bus.valid_m = 1'b1;
    ext_int     = 6'b000010;
    bad = 0;
    for (int k = 0; k < SYNC + 3; k++) begin
      tick();
      if (bus.flush !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL int_exl got=%0d flushes want=0", bad);
    end
    bus.valid_m = 1'b0;
    ext_int     = '0;
    cp0_status  = '0;
    repeat (SYNC + 2) tick();
  endtask

  task automatic test_timer();
    int bad = 0;
    cp0_write(5'd11, 32'd3);
    cp0_write(5'd9, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (count !== 32'(k / 2)) bad++;
      if (timer_int !== (k >= 7)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL timer_match got=%0d bad samples want=0", bad);
    end
    checks++;
    if (hw_ip[5] !== 1'b1) begin
      errors++;
      $display("FAIL timer_ip7 got=%b want=1", hw_ip[5]);
    end
    cp0_write(5'd11, 32'd1000);
    checks++;
    if (timer_int !== 1'b0) begin
      errors++;
      $display("FAIL timer_clear got=%b want=0", timer_int);
    end
    cp0_write(5'd11, 32'd2);
    cp0_write(5'd9, 32'd0);
    repeat (4) tick();
    cp0_write(5'd11, 32'd500);
    tick();
    checks++;
    if ({timer_int, compare} !== {1'b0, 32'd500}) begin
      errors++;
      $display("FAIL timer_race ti=%b cmp=%0d want=0/500",
               timer_int, compare);
    end
  endtask

  task automatic test_async_reset();
    bus.valid_m = 1'b1;
    bus.pc_m    = 32'h80000200;
    set_flags(8'h80);
    tick();
    clear_m();
    checks++;
    if (bus.flush !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got=%b want=1", bus.flush);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({pulses(), count} !== 36'd0) begin
      errors++;
      $display("FAIL arst_drop p=%b count=%h want=0",
               pulses(), count);
    end
    tick();
    resetn = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_idle();
    test_ov();
    test_combo();
    test_random();
    test_eret_hold();
    test_interrupt();
    test_timer();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
Parametrised, registered successor to the M-stage exception resolver. It prioritises exceptions and interrupts for the instruction in M and emits a one-cycle flush/redirect with commit data for CP0. It also owns the interrupt-line synchroniser and the Count/Compare timer. It sits between the M stage, CP0 and the PC/flush logic in the pipeline top.

Parameters:
NUM_EXT_INT, 6, number of external interrupt lines (1..6), mapped to Cause.IP[2 +: NUM_EXT_INT]
SYNC_STAGES, 2, flip-flop stages on each ext_int line (>=1)
EXC_VECTOR, 32'hBFC00380, redirect target for every exception except eret
TIMER_EN, 1, 1 = internal Count/Compare present and ORed into IP7; 0 = count/compare read 0 and timer_int=0

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ext_int  in  NUM_EXT_INT  raw external interrupt lines
valid_m  in  1  M-stage holds a real instruction
pc_m  in  32  PC of M instruction
bd_m  in  1  M instruction is in a delay slot
mem_addr_m  in  32  data address of M load/store
adel_if, adel_mem, ades, syscall, brk, eret, ri, ov  in  1 each  exception flags of M instruction
cp0_status  in  32  Status (IM[15:8], EXL[1], IE[0])
cp0_cause  in  32  Cause (software IP[9:8] used)
cp0_epc  in  32  EPC, eret target
cp0_we  in  1  CP0 write strobe
cp0_waddr  in  5  CP0 register number (9 = Count, 11 = Compare)
cp0_wdata  in  32  write data
flush  out  1  one-cycle pipeline flush pulse
redirect_pc  out  32  new PC, valid while flush=1
exc_commit  out  1  pulse: CP0 must write EPC/Cause.ExcCode/BD and set EXL
exc_code  out  5  ExcCode for exc_commit
exc_bd  out  1  BD bit for exc_commit
exc_epc  out  32  EPC value for exc_commit
badvaddr_we  out  1  pulse: CP0 must load BadVAddr
badvaddr  out  32  BadVAddr value
eret_commit  out  1  pulse: CP0 must clear EXL
hw_ip  out  6  synchronised IP[7:2], timer included, for Cause
timer_int  out  1  timer interrupt pending (Cause.TI)
count  out  32  Count register
compare  out  32  Compare register

Behaviour:
- Reset: all outputs, state, count, compare, timer_int and synchroniser flops are 0. State is IDLE.
- Synchroniser: ext_int passes through SYNC_STAGES flops, then zero-extends to 6 bits as hw_ip.
- hw_ip[5] = sync[5] | timer_int when TIMER_EN=1.
- Interrupt request: (({hw_ip, cp0_cause[9:8]} & cp0_status[15:8]) != 0) && !EXL && IE.
- Detection runs only in IDLE with valid_m=1. Priority, highest first:
  - int (code 0x00)
  - adel_if or adel_mem (0x04)
  - ades (0x05)
  - syscall (0x08)
  - brk (0x09)
  - eret
  - ri (0x0A)
  - ov (0x0C)
- Latency 1: the decision is made in cycle N; registered outputs pulse in cycle N+1 for exactly one cycle.
- Exception taken:
  - flush=1, redirect_pc=EXC_VECTOR, exc_commit=1, exc_code as above.
  - exc_bd=bd_m; exc_epc = bd_m ? pc_m-4 : pc_m.
- AdEL/AdES:
  - badvaddr_we=1.
  - badvaddr=pc_m if adel_if, else mem_addr_m.
  - adel_if wins over adel_mem.
- eret: flush=1, redirect_pc=cp0_epc (sampled in cycle N), eret_commit=1, exc_commit=0.
- FSM:
  - IDLE -> TAKEN on any detection.
  - TAKEN (outputs pulse) -> HOLD.
  - HOLD -> IDLE.
  - Flags and interrupts arriving in TAKEN/HOLD are ignored; the flushed instructions must not retrigger.
- Timer (TIMER_EN=1):
  - A toggle bit flips every cycle; count increments when toggle=1, i.e. every 2 cycles, wrapping 0xFFFFFFFF -> 0.
  - A count write loads cp0_wdata and clears toggle.
  - A compare write loads compare and clears timer_int.
  - timer_int sets in the cycle after count (post-update) equals compare.
  - A compare write in the same cycle as a match wins: timer_int stays 0.
  - A count write in the same cycle as an increment wins.
- Asynchronous reset mid-pulse drops flush and all other pulses immediately.

Test Plan:
- Reset, then release. Run 10 cycles with no stimulus -> all pulses 0; count=5 at cycle 10 (±toggle phase); hw_ip=0.
- valid_m=1, pc_m=0xBFC00100, ov=1, bd_m=0 in cycle N -> cycle N+1: flush=1, redirect_pc=0xBFC00380, exc_code=0x0C, exc_epc=0xBFC00100. Cycle N+2: all pulses 0.
- Flags set together: adel_mem=1, mem_addr_m=0x00000003, syscall=1, bd_m=1, pc_m=0x80000010 -> exc_code=0x04, badvaddr_we=1, badvaddr=0x3, exc_bd=1, exc_epc=0x8000000C.
- Status=0x0000FF01, ext_int[1] rises -> interrupt taken exactly SYNC_STAGES+1 cycles later, exc_code=0x00. The same with Status.EXL=1 -> no flush.
- eret with cp0_epc=0x80001234 -> flush=1, redirect_pc=0x80001234, eret_commit=1, exc_commit=0. ri asserted in the following 2 cycles -> ignored (HOLD).
- Write compare=3, then count=0 -> timer_int=1 after count reaches 3; hw_ip[5]=1. A compare write -> timer_int=0 next cycle. Simultaneous match and compare write -> timer_int stays 0.
